// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm fade sequencer: FSM state encoding and reset constants.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RISE  = 2'd1,
    ST_FALL  = 2'd2,
    ST_DRAIN = 2'd3
  } fade_state_e;

  localparam int TOP_RST = 255;
  localparam int MAX_RST = 255;
  localparam int TOP_MIN = 2;

endpackage

// File: rtl/pwm_period_tracker.sv
// Mirrors a pwm counter sharing clk/rst: counts 0..P-1 and flags the last cycle of each period.
module pwm_period_tracker #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] top,
  input  logic         mode,
  output logic [W:0]   pcnt,
  output logic         period_o
);

  logic [W:0] pcnt_q, pcnt_d;
  logic [W:0] last;

  // Sawtooth period is top+1 cycles, triangle period is 2*top cycles.
  always_comb begin
    last     = mode ? ({top, 1'b0} - (W+1)'(1)) : {1'b0, top};
    period_o = (pcnt_q == last);
    pcnt_d   = period_o ? '0 : pcnt_q + (W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

  assign pcnt = pcnt_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing-ramp sequencer driving top/comp/mode of one pwm channel, changes applied on period boundaries.
// Optional build macro PWM_FADE_GAMMA_EN selects a squared level-to-compare curve.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int W      = 16,
  parameter int LVL_W  = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [W-1:0]      cfg_top,
  input  logic              cfg_mode,
  input  logic [LVL_W-1:0]  cfg_min,
  input  logic [LVL_W-1:0]  cfg_max,
  input  logic [LVL_W-1:0]  cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              start,
  input  logic              stop,
  output logic [W-1:0]      top_o,
  output logic [W-1:0]      comp_o,
  output logic              mode_o,
  output logic              period_o,
  output logic              busy
);

  fade_state_e state_q, state_d, act_st;
  logic [LVL_W-1:0]  level_q, level_d, min_q, min_d, max_q, max_d, step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hcnt_q, hcnt_d;
  logic [W-1:0]      top_q, top_d, comp_q, comp_d;
  logic              mode_q, mode_d, pending_q, pending_d, start_q, start_d, stop_q, stop_d;
  logic [W-1:0]      sh_top_q, sh_top_d;
  logic              sh_mode_q, sh_mode_d;
  logic [LVL_W-1:0]  sh_min_q, sh_min_d, sh_max_q, sh_max_d, sh_step_q, sh_step_d;
  logic [HOLD_W-1:0] sh_hold_q, sh_hold_d;

  logic [W-1:0]      c_top;
  logic [LVL_W-1:0]  c_min, c_max, c_step, up_sat, dn_sat;
  logic [HOLD_W-1:0] c_hold;
  logic [LVL_W:0]    up, dn;
  logic              go_start, go_stop, period;
  logic [W:0]        pcnt_unused;

  function automatic logic [W-1:0] level_to_comp(input logic [LVL_W-1:0] lvl,
                                                  input logic [W-1:0] t);
`ifdef PWM_FADE_GAMMA_EN
    logic [W+2*LVL_W-1:0] p;
    p = (W+2*LVL_W)'(lvl) * (W+2*LVL_W)'(lvl) * (W+2*LVL_W)'(t);
    return p[2*LVL_W +: W];
`else
    logic [W+LVL_W-1:0] p;
    p = (W+LVL_W)'(lvl) * (W+LVL_W)'(t);
    return p[LVL_W +: W];
`endif
  endfunction

  // Only the boundary matters here; the in-period position is left for other users.
  pwm_period_tracker #(.W(W)) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .top      (top_q),
    .mode     (mode_q),
    .pcnt     (pcnt_unused),
    .period_o (period)
  );

  // Config handshake: a word transfers on a cycle with cfg_valid & cfg_ready; cfg_ready depends
  // only on registered state, so the sender may hold cfg_valid and its fields until it sees ready.
  assign cfg_ready = (state_q == ST_IDLE) && !pending_q;
  assign busy      = (state_q != ST_IDLE);
  assign top_o     = top_q;
  assign comp_o    = comp_q;
  assign mode_o    = mode_q;
  assign period_o  = period;

  always_comb begin
    state_d   = state_q;   level_d = level_q; hcnt_d = hcnt_q;
    min_d     = min_q;     max_d   = max_q;   step_d = step_q; hold_d = hold_q;
    top_d     = top_q;     mode_d  = mode_q;  comp_d = comp_q;
    pending_d = pending_q;
    sh_top_d  = sh_top_q;  sh_mode_d = sh_mode_q; sh_min_d  = sh_min_q;
    sh_max_d  = sh_max_q;  sh_step_d = sh_step_q; sh_hold_d = sh_hold_q;

    // A pending config takes effect at the same boundary it is copied in.
    c_top  = pending_q ? sh_top_q  : top_q;
    c_min  = pending_q ? sh_min_q  : min_q;
    c_max  = pending_q ? sh_max_q  : max_q;
    c_step = pending_q ? sh_step_q : step_q;
    c_hold = pending_q ? sh_hold_q : hold_q;

    go_start = start_q | start;
    go_stop  = stop_q | stop;
    start_d  = go_start;
    stop_d   = go_stop;

    up     = {1'b0, level_q} + {1'b0, c_step};
    dn     = {1'b0, level_q} - {1'b0, c_step};
    up_sat = (up > {1'b0, c_max}) ? c_max : up[LVL_W-1:0];
    dn_sat = (dn[LVL_W] || (dn[LVL_W-1:0] < c_min)) ? c_min : dn[LVL_W-1:0];
    act_st = (state_q != ST_IDLE && go_stop) ? ST_DRAIN : state_q;

    if (cfg_valid && cfg_ready) begin
      sh_top_d  = (cfg_top < W'(TOP_MIN)) ? W'(TOP_MIN) : cfg_top;
      sh_mode_d = cfg_mode;
      sh_min_d  = cfg_min;
      sh_max_d  = (cfg_max < cfg_min) ? cfg_min : cfg_max;
      sh_step_d = (cfg_step == '0) ? LVL_W'(1) : cfg_step;
      sh_hold_d = cfg_hold;
      pending_d = 1'b1;
    end

    if (period) begin
      start_d = 1'b0;
      stop_d  = 1'b0;
      if (pending_q) begin
        top_d  = sh_top_q;  mode_d = sh_mode_q; min_d  = sh_min_q;
        max_d  = sh_max_q;  step_d = sh_step_q; hold_d = sh_hold_q;
        pending_d = 1'b0;
      end
      state_d = act_st;
      if (act_st == ST_IDLE) begin
        level_d = c_min;
        hcnt_d  = '0;
        if (go_start && !go_stop) state_d = ST_RISE;
      end else if (hcnt_q >= c_hold) begin
        hcnt_d = '0;
        if (act_st == ST_RISE) begin
          level_d = up_sat;
          if (up_sat == c_max) state_d = ST_FALL;
        end else begin
          level_d = dn_sat;
          if (dn_sat == c_min) begin
            if (act_st == ST_FALL) state_d = ST_RISE;
            else                   state_d = ST_IDLE;
          end
        end
      end else begin
        hcnt_d = hcnt_q + HOLD_W'(1);
      end
      comp_d = level_to_comp(level_d, c_top);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;          level_q <= '0;
      min_q     <= '0;               max_q   <= LVL_W'(MAX_RST);
      step_q    <= LVL_W'(1);        hold_q  <= '0;
      hcnt_q    <= '0;               top_q   <= W'(TOP_RST);
      mode_q    <= 1'b0;             comp_q  <= '0;
      pending_q <= 1'b0;             start_q <= 1'b0;
      stop_q    <= 1'b0;             sh_top_q <= W'(TOP_RST);
      sh_mode_q <= 1'b0;             sh_min_q <= '0;
      sh_max_q  <= LVL_W'(MAX_RST);  sh_step_q <= LVL_W'(1);
      sh_hold_q <= '0;
    end else begin
      state_q   <= state_d;          level_q <= level_d;
      min_q     <= min_d;            max_q   <= max_d;
      step_q    <= step_d;           hold_q  <= hold_d;
      hcnt_q    <= hcnt_d;           top_q   <= top_d;
      mode_q    <= mode_d;           comp_q  <= comp_d;
      pending_q <= pending_d;        start_q <= start_d;
      stop_q    <= stop_d;           sh_top_q <= sh_top_d;
      sh_mode_q <= sh_mode_d;        sh_min_q <= sh_min_d;
      sh_max_q  <= sh_max_d;         sh_step_q <= sh_step_d;
      sh_hold_q <= sh_hold_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: expected compare values are queued when a ramp is
// started and popped at each period boundary; a small pwm counter model checks alignment.
module tb_pwm_fade_ctrl;

  localparam int W      = 16;
  localparam int LVL_W  = 8;
  localparam int HOLD_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              cfg_valid, cfg_ready, cfg_mode, start, stop;
  logic [W-1:0]      cfg_top, top_o, comp_o;
  logic [LVL_W-1:0]  cfg_min, cfg_max, cfg_step;
  logic [HOLD_W-1:0] cfg_hold;
  logic              mode_o, period_o, busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int lv_saw[11]  = '{0, 64, 128, 192, 255, 191, 127, 63, 0, 64, 128};
  int lv_hold[9]  = '{0, 0, 0, 0, 64, 64, 64, 64, 128};
  int lv_tri[6]   = '{0, 64, 128, 192, 255, 191};

  pwm_fade_ctrl #(.W(W), .LVL_W(LVL_W), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_top   (cfg_top),
    .cfg_mode  (cfg_mode),
    .cfg_min   (cfg_min),
    .cfg_max   (cfg_max),
    .cfg_step  (cfg_step),
    .cfg_hold  (cfg_hold),
    .start     (start),
    .stop      (stop),
    .top_o     (top_o),
    .comp_o    (comp_o),
    .mode_o    (mode_o),
    .period_o  (period_o),
    .busy      (busy)
  );

  // Reference pwm counter driven by the DUT outputs; its state must be 0 right after a boundary.
  logic [W-1:0] pwm_cnt;
  logic         pwm_down;
  always @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0; pwm_down <= 1'b0;
    end else if (!mode_o) begin
      pwm_down <= 1'b0;
      pwm_cnt  <= (pwm_cnt >= top_o) ? '0 : pwm_cnt + 1'b1;
    end else if (!pwm_down) begin
      if (pwm_cnt >= top_o) begin pwm_down <= 1'b1; pwm_cnt <= pwm_cnt - 1'b1; end
      else pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      if (pwm_cnt <= 1) begin pwm_down <= 1'b0; pwm_cnt <= '0; end
      else pwm_cnt <= pwm_cnt - 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_comp(input int lvl, input int t);
    longint p;
`ifdef PWM_FADE_GAMMA_EN
    p = (longint'(lvl) * lvl * t) >> (2 * LVL_W);
`else
    p = (longint'(lvl) * t) >> LVL_W;
`endif
    return W'(p);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after the next boundary.
  task automatic wait_boundary(input string tag);
    int n = 0;
    while (period_o !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check({tag, "_boundary"}, period_o, 1);
    @(negedge clk);
  endtask

  // Called in the first cycle of a period; returns the period length in cycles.
  task automatic measure_period(output int len);
    len = 1;
    while (period_o !== 1'b1 && len < 2000) begin @(negedge clk); len++; end
    @(negedge clk);
  endtask

  task automatic send_cfg(input int t, input int m, input int mn, input int mx,
                          input int st, input int h);
    int n = 0;
    cfg_top = W'(t); cfg_mode = m[0]; cfg_min = LVL_W'(mn); cfg_max = LVL_W'(mx);
    cfg_step = LVL_W'(st); cfg_hold = HOLD_W'(h); cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("cfg_ready_wait", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_pending", cfg_ready, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  // Pops one expected compare per boundary while the ramp runs.
  task automatic run_scoreboard(input string tag, input bit mid);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      wait_boundary(tag);
      e = exp_q.pop_front();
      check({tag, "_comp"}, comp_o, e);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_pwm0"}, pwm_cnt, 0);
      if (mid) begin
        repeat (8) @(negedge clk);
        check({tag, "_stable"}, comp_o, e);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_top"},   top_o, 255);
    check({tag, "_mode"},  mode_o, 0);
    check({tag, "_comp"},  comp_o, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_ready"}, cfg_ready, 1);
    check({tag, "_period"}, period_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cfg_top = '0; cfg_mode = 1'b0; cfg_min = '0; cfg_max = '0; cfg_step = '0; cfg_hold = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst");

    // Sawtooth config, applied at the first boundary.
    send_cfg(16, 0, 0, 255, 64, 0);
    wait_boundary("saw_cfg");
    check("saw_top", top_o, 16);
    check("saw_mode", mode_o, 0);
    check("saw_idle_comp", comp_o, exp_comp(0, 16));
    check("saw_ready", cfg_ready, 1);
    measure_period(len); check("saw_period", len, 17);
    measure_period(len); check("saw_period2", len, 17);

    pulse_start();
    foreach (lv_saw[i]) exp_q.push_back(exp_comp(lv_saw[i], 16));
    run_scoreboard("saw", 1'b0);

    // Now rising at level 128: config offered while busy, then stop.
    stop = 1'b1; cfg_valid = 1'b1; cfg_top = 16'd99; cfg_mode = 1'b1;
    check("busy_ready", cfg_ready, 0);
    @(negedge clk); stop = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_ready2", cfg_ready, 0);
    cfg_valid = 1'b0;
    wait_boundary("drain1");
    check("drain1_comp", comp_o, exp_comp(64, 16));
    check("drain1_busy", busy, 1);
    check("drain1_top", top_o, 16);
    check("drain1_mode", mode_o, 0);
    wait_boundary("drain2");
    check("drain2_comp", comp_o, exp_comp(0, 16));
    check("drain2_busy", busy, 0);
    repeat (2) begin
      wait_boundary("idle_hold");
      check("idle_hold_comp", comp_o, exp_comp(0, 16));
      check("idle_hold_busy", busy, 0);
    end
    check("idle_ready", cfg_ready, 1);

    // Clamping: top 0 becomes 2.
    send_cfg(0, 0, 0, 255, 64, 0);
    wait_boundary("clamp_top");
    check("clamp_top", top_o, 2);
    measure_period(len); check("clamp_period", len, 3);

    // max < min and step 0: level pinned at 128.
    send_cfg(16, 0, 128, 64, 0, 0);
    wait_boundary("pin_cfg");
    check("pin_idle_comp", comp_o, exp_comp(128, 16));
    pulse_start();
    repeat (4) exp_q.push_back(exp_comp(128, 16));
    run_scoreboard("pin", 1'b0);
    pulse_stop();
    wait_boundary("pin_stop");
    check("pin_stop_busy", busy, 0);
    check("pin_stop_comp", comp_o, exp_comp(128, 16));

    // Hold of 3: a step every fourth boundary, comp steady in between.
    send_cfg(16, 0, 0, 255, 64, 3);
    wait_boundary("hold_cfg");
    pulse_start();
    foreach (lv_hold[i]) exp_q.push_back(exp_comp(lv_hold[i], 16));
    run_scoreboard("hold", 1'b1);
    do_reset();

    // Triangle mode: 32-cycle periods aligned with the pwm counter.
    send_cfg(16, 1, 0, 255, 64, 0);
    wait_boundary("tri_cfg");
    check("tri_mode", mode_o, 1);
    check("tri_top", top_o, 16);
    measure_period(len); check("tri_period", len, 32);
    check("tri_pwm0", pwm_cnt, 0);
    measure_period(len); check("tri_period2", len, 32);
    pulse_start();
    foreach (lv_tri[i]) exp_q.push_back(exp_comp(lv_tri[i], 16));
    run_scoreboard("tri", 1'b0);

    // Reset while falling.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");

    // Level 128 at top 256 in idle.
    send_cfg(256, 0, 128, 128, 1, 0);
    wait_boundary("map");
    check("map_comp", comp_o, exp_comp(128, 256));
    check("map_top", top_o, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Sequencer that drives the `top`, `comp` and `mode` inputs of one pwm channel. It produces a "breathing" brightness ramp: the duty level rises from a minimum to a maximum and back, one step every N PWM periods. It keeps a period counter that mirrors the pwm counter exactly when both share `clk`/`rst`, so every change is applied on a PWM period boundary and no output glitches. Configuration is written through a valid/ready port, and `start`/`stop` control the ramp.

## Interface
- `W`, 16, width of `top`/`comp`
- `LVL_W`, 8, width of duty level (0..2^LVL_W-1)
- `HOLD_W`, 8, width of hold count (periods per step)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high; shared with the driven pwm
- `cfg_valid`  in  1  config offered
- `cfg_ready`  out  1  config accepted when `cfg_valid & cfg_ready`
- `cfg_top`  in  W  PWM top
- `cfg_mode`  in  1  0 = sawtooth, 1 = triangle (same meaning as pwm `mode`)
- `cfg_min`  in  LVL_W  lowest level
- `cfg_max`  in  LVL_W  highest level
- `cfg_step`  in  LVL_W  level increment per step
- `cfg_hold`  in  HOLD_W  periods per step, minus 1
- `start`  in  1  begin ramping (pulse)
- `stop`  in  1  finish ramp down to min, then idle (pulse)
- `top_o`  out  W  to pwm `top`
- `comp_o`  out  W  to pwm `comp`
- `mode_o`  out  1  to pwm `mode`
- `period_o`  out  1  high on last cycle of each PWM period
- `busy`  out  1  FSM not IDLE

## Operation
- Period counter `pcnt` runs 0..P-1.
  - P = `top_o`+1 when `mode_o`=0; P = 2·`top_o` when `mode_o`=1.
  - `pcnt`=0 is the cycle in which the pwm state is 0.
  - `period_o` = (`pcnt`==P-1). This is the boundary.
- Config handshake:
  - `cfg_ready` = (state==IDLE) & !pending.
  - On accept, all fields go into shadow registers and pending=1.
  - At the next boundary, shadow values are copied to active registers and `top_o`/`mode_o`, and pending clears.
  - `cfg_top`<2 is clamped to 2.
  - `cfg_max`<`cfg_min` is stored as `cfg_max`=`cfg_min`.
  - `cfg_step`=0 is stored as 1.
- FSM states: IDLE, RISE, FALL, DRAIN. All transitions and level updates happen only at a boundary.
  - IDLE: `start` (latched until the boundary) loads level=min, holds 0, and goes to RISE. `stop` in IDLE is ignored. `start` and `stop` latched together in IDLE: stop wins and the FSM stays in IDLE.
  - RISE: the hold counter counts boundaries. When it reaches `cfg_hold`, level = min(level+step, max) and the counter resets. If the new level == max, go to FALL.
  - FALL: same as RISE, but level = max(level-step, min). At level == min, go to RISE.
  - `stop` in RISE/FALL goes to DRAIN. DRAIN is FALL that exits to IDLE at level == min.
  - `start` while busy is ignored.
  - min == max: level stays constant, and RISE/FALL alternate each step.
- Level-to-compare mapping (registered, updated at the boundary): `comp_o` = (level·`top_o`) >> LVL_W.
- Arithmetic:
  - level±step is computed LVL_W+1 wide, then saturated.
  - Products are W+LVL_W wide (W+2·LVL_W for gamma), then truncated after the shift.
- IDLE output: `comp_o` = (min·`top_o`) >> LVL_W, i.e. the comp for level=min.
- `rst` at any time returns every register to its reset value, aborting the ramp. Shadow config and pending are discarded.

## Timing
- Reset values:
  - `top_o`=255, `mode_o`=0, `comp_o`=0
  - level=0, min=0, max=255, step=1, hold=0
  - `pcnt`=0, pending=0
  - state=IDLE, `busy`=0
  - `cfg_ready`=1 in the first cycle after `rst` deasserts
- All outputs are registered.
- New `top_o`/`mode_o`/`comp_o` values appear in the cycle after `period_o`=1, i.e. at `pcnt`=0.
- Worst-case config latency: one full period after accept.
- `busy` rises in the cycle after the boundary that acts on `start`. It falls in the cycle after the boundary that reaches min in DRAIN.
- `start`/`stop` are single-cycle pulses. They are captured into sticky flags, and the flags clear at the boundary that consumes them.

## Configuration
- `PWM_FADE_GAMMA_EN`
  - Defined: `comp_o` = (level·level·`top_o`) >> (2·LVL_W), a squared perceptual curve.
  - Undefined: linear mapping as above. The squaring multiplier is absent.
- Ports and FSM are identical in both builds.

## Structure
- Shared package `pwm_pkg`:
  - FSM state enum (IDLE/RISE/FALL/DRAIN)
  - reset constants (`TOP_RST`=255, `MAX_RST`=255)
  - `TOP_MIN`=2
- Sub-module `pwm_period_tracker`:
  - inputs: `top`, `mode`
  - outputs: `pcnt`, `period_o`
  - reusable by any block that must align to pwm periods.

## Test plan
- Reset, then a sawtooth configuration:
  - Stimulus: reset; accept top=16, mode=0, min=0, max=255, step=64, hold=0; `start`.
  - Required: `period_o` every 17 cycles. `comp_o` sequence per period is 0, 4, 8, 12, 15, 11, 7, 3, 0…, saturating at 255→15.
- Triangle mode: accept top=16, mode=1 → `period_o` every 32 cycles. A pwm instance driven by the outputs shows its state is 0 exactly when `pcnt`=0.
- Hold: hold=3 → level changes every 4th boundary only. `comp_o` is stable between changes.
- Stop while rising: `stop` during RISE at level=128 → FALL, then IDLE at min. `busy` drops the cycle after that boundary; a later `start` is required to resume.
- Config rejection and clamping:
  - `cfg_valid` while busy → `cfg_ready`=0, no change.
  - top=0 accepted in IDLE → `top_o`=2 after the next boundary.
  - max<min → level constant.
- Reset mid-ramp and gamma build: `rst` during FALL → all reset values the next cycle. With `PWM_FADE_GAMMA_EN`, level=128, top=256 → `comp_o`=64.
